fd_gen: RTL
===========

Name: fd_gen

Overview:
- Frame-sync transmitter. Generates the periodic frame-sync level `fd` (default 5 kHz from the 25 MHz `clk`) that downstream edge detectors turn into single-cycle frame pulses.
- Also emits its own one-cycle `frame_strb` aligned to each `fd` rising edge.
- Period and high time are programmable at runtime. An external `sync` pulse realigns the frame phase.
- Sits at the imitator's timing root and drives all channel sequencers.

Parameters:
- CNT_W, 16, width of the period/high counters and config ports
- PERIOD_DEF, 5000, reset-value period in clk cycles (5 kHz at 25 MHz)
- HIGH_DEF, 2500, reset-value high time in clk cycles

Ports:
- clk  in  1  25 MHz system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  level; 1 = generate frames
- load  in  1  one-cycle strobe; latch `period_i`/`high_i`
- period_i  in  CNT_W  requested frame period, cycles
- high_i  in  CNT_W  requested `fd` high time, cycles
- sync  in  1  one-cycle strobe; restart frame phase
- fd  out  1  frame-sync level
- frame_strb  out  1  one-cycle pulse, coincident with each `fd` rise
- active  out  1  1 while not IDLE
- cfg_err  out  1  sticky; last load was rejected

Behaviour:
- Reset (async, rst=1):
  - Outputs: fd=0, frame_strb=0, active=0, cfg_err=0.
  - Internal: state=IDLE, cnt=0, period_r=PERIOD_DEF, high_r=HIGH_DEF, pending=0.
  - All outputs are registered.
- States: IDLE, HIGH, LOW.
- IDLE:
  - fd=0. `sync` is ignored.
  - en=1 sampled at edge E → frame start at edge E: state=HIGH, cnt=0, fd=1, frame_strb=1, active=1.
- Frame start, common to every case: cnt←0, fd←1, frame_strb←1 for exactly one cycle, pending config applied.
- HIGH: cnt increments each cycle. When cnt==high_r-1 → LOW, fd←0.
- LOW: cnt increments each cycle. When cnt==period_r-1:
  - en=1 → frame start.
  - en=0 → IDLE, active←0, fd stays 0.
- Resulting waveform: with the frame start at edge T0, fd is high during cycles T0..T0+high_r-1 and low through T0+period_r-1. The next rise is at T0+period_r.
- en deasserted mid-frame: the current frame completes fully, then the block goes IDLE. There are no truncated frames.
- `sync` in HIGH or LOW: forces a frame start at the next edge, regardless of cnt.
  - sync together with the natural period end gives one frame start, not two.
  - sync with en=0 in HIGH/LOW is ignored; the frame finishes and the block goes IDLE.
- Config validity: period_i≥2 and 1≤high_i<period_i.
  - Valid load in IDLE: period_r/high_r update next edge; cfg_err←0.
  - Valid load in HIGH/LOW: values held in pending registers; cfg_err←0. They are applied at the next frame start, natural or sync-forced. A newer valid load overwrites the pending values.
  - Invalid load: values discarded, pending unchanged, cfg_err←1 (sticky until the next valid load).
- load in the same cycle as a frame start: the new values are not used for that frame; they apply at the following frame start.
- Counter arithmetic: unsigned CNT_W. cnt never exceeds period_r-1, so no wrap is possible.
- Reset mid-frame: immediate return to reset values. Pending config is lost; period_r/high_r return to the defaults.

Decomposition:
- Shared package fd_pkg contains:
  - the state enum (IDLE/HIGH/LOW);
  - the PERIOD_DEF/HIGH_DEF localparams for 25 MHz/5 kHz;
  - a `cfg_valid` function that is reused by channel blocks.
- One sub-module, fd_cfg_reg: load validation plus the active/pending config registers. It outputs period_r, high_r and cfg_err, and takes an `apply` strobe from the FSM.
- FSM and counter stay in fd_gen.

Test Plan:
- Defaults: reset, then en=1 held for 3 frames → fd rises every 5000 cycles, high exactly 2500 cycles. frame_strb is one cycle wide, coincident with each rise. active=1.
- Runtime reconfig: load period_i=10, high_i=3 mid-frame → current frame keeps 5000/2500, subsequent frames are 10/3. No frame_strb glitch at the switch.
- Phase resync: period=10/high=3, sync pulsed at cnt=6 (LOW) → fd rises at the next edge with frame_strb. The next rise follows 10 cycles later. Also sync at cnt=9 → exactly one frame start.
- Invalid config: load 5/5, then 1/0 → cfg_err=1, timing stays 10/3. Then load 8/4 → cfg_err=0, 8/4 from the next frame.
- Enable drop: en=0 at cnt=1 of a 10/3 frame → frame completes (fd high 3, low 7), then IDLE with fd=0 and active=0. sync in IDLE → no output.
- Async reset mid-HIGH: rst=1 between edges → fd, frame_strb and active fall without waiting for a clk edge. After release with en=1 → 5000/2500 defaults resume.

Source files
------------

// File: rtl/fd_pkg.sv
// ============================================================================
//  Module   : fd_pkg
//  Purpose  : Shared types, defaults and config check for the frame-sync
//             generator and the channel blocks it drives.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } fd_state_t;

  // 5 kHz frame with 50 % duty from a 25 MHz clock
  localparam int FD_PERIOD_DEF = 5000;
  localparam int FD_HIGH_DEF   = 2500;

  // A frame needs at least one high and one low cycle
  function automatic logic cfg_valid(input logic [31:0] period, input logic [31:0] high);
    return (period >= 32'd2) && (high >= 32'd1) && (high < period);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fd_gen_if.sv
// ============================================================================
//  Module   : fd_gen_if
//  Purpose  : Control / status bundle of the frame-sync generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fd_gen_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             load;
  logic [CNT_W-1:0] period_i;
  logic [CNT_W-1:0] high_i;
  logic             sync;
  logic             fd;
  logic             frame_strb;
  logic             active;
  logic             cfg_err;

  modport master (
    output en, load, period_i, high_i, sync,
    input  fd, frame_strb, active, cfg_err
  );

  modport slave (
    input  en, load, period_i, high_i, sync,
    output fd, frame_strb, active, cfg_err
  );
endinterface

`default_nettype wire

// File: rtl/fd_cfg_reg.sv
// ============================================================================
//  Module   : fd_cfg_reg
//  Purpose  : Validates runtime period/high loads and holds the active and
//             pending frame configuration. Pending values take effect on
//             the apply strobe (frame start).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fd_cfg_reg
  import fd_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int PERIOD_DEF = FD_PERIOD_DEF,
  parameter int HIGH_DEF   = FD_HIGH_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_period,
  input  wire logic [CNT_W-1:0] i_high,
  input  wire logic             i_idle,
  input  wire logic             i_apply,
  output logic      [CNT_W-1:0] o_period,
  output logic      [CNT_W-1:0] o_high,
  output logic                  o_cfg_err
);

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_pend_period;
  logic [CNT_W-1:0] r_pend_high;
  logic             r_pend_vld;
  logic             r_cfg_err;
  logic             w_valid;

  assign w_valid = cfg_valid(32'(i_period), 32'(i_high));

  // Load validation, direct update while idle, deferred update while framing.
  // A load coinciding with a frame start is deferred so it never alters the
  // frame that is just beginning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period      <= CNT_W'(PERIOD_DEF);
      r_high        <= CNT_W'(HIGH_DEF);
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_pend_vld    <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      if (i_apply && r_pend_vld) begin
        r_period   <= r_pend_period;
        r_high     <= r_pend_high;
        r_pend_vld <= 1'b0;
      end
      if (i_load) begin
        if (w_valid) begin
          r_cfg_err <= 1'b0;
          if (i_idle && !i_apply) begin
            // Direct write supersedes anything still pending
            r_period   <= i_period;
            r_high     <= i_high;
            r_pend_vld <= 1'b0;
          end else begin
            r_pend_period <= i_period;
            r_pend_high   <= i_high;
            r_pend_vld    <= 1'b1;
          end
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

  assign o_period  = r_period;
  assign o_high    = r_high;
  assign o_cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: rtl/fd_gen.sv
// ============================================================================
//  Module   : fd_gen
//  Purpose  : Frame-sync transmitter. Produces the periodic fd level and a
//             one-cycle frame strobe on every rise, with runtime period/high
//             programming and external phase resynchronisation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fd_gen
  import fd_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int PERIOD_DEF = FD_PERIOD_DEF,
  parameter int HIGH_DEF   = FD_HIGH_DEF
) (
  input wire logic clk,
  input wire logic rst,
  fd_gen_if.slave  bus
);

  fd_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fd;
  logic             r_strb;
  logic             r_active;

  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_high;
  logic             w_cfg_err;
  logic             w_in_frame;
  logic             w_high_end;
  logic             w_period_end;
  logic             w_start;

  assign w_in_frame   = (r_state != ST_IDLE);
  assign w_high_end   = (r_state == ST_HIGH) && (r_cnt == w_high - CNT_W'(1));
  assign w_period_end = (r_state == ST_LOW) && (r_cnt == w_period - CNT_W'(1));
  // Sync only matters mid-frame; from IDLE en alone starts a frame, and a
  // sync landing on the natural period end merges into the same start.
  assign w_start      = bus.en && (!w_in_frame || bus.sync || w_period_end);

  fd_cfg_reg #(
    .CNT_W      (CNT_W),
    .PERIOD_DEF (PERIOD_DEF),
    .HIGH_DEF   (HIGH_DEF)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (bus.load),
    .i_period  (bus.period_i),
    .i_high    (bus.high_i),
    .i_idle    (!w_in_frame),
    .i_apply   (w_start),
    .o_period  (w_period),
    .o_high    (w_high),
    .o_cfg_err (w_cfg_err)
  );

  // Frame FSM with phase counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_fd     <= 1'b0;
      r_strb   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_strb <= 1'b0;
      if (w_start) begin
        r_state  <= ST_HIGH;
        r_cnt    <= '0;
        r_fd     <= 1'b1;
        r_strb   <= 1'b1;
        r_active <= 1'b1;
      end else begin
        case (r_state)
          ST_HIGH: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_high_end) begin
              r_state <= ST_LOW;
              r_fd    <= 1'b0;
            end
          end
          ST_LOW: begin
            if (w_period_end) begin
              r_state  <= ST_IDLE;
              r_cnt    <= '0;
              r_active <= 1'b0;
              r_fd     <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_fd     <= 1'b0;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fd         = r_fd;
  assign bus.frame_strb = r_strb;
  assign bus.active     = r_active;
  assign bus.cfg_err    = w_cfg_err;

endmodule

`default_nettype wire
